// File: rtl/nos_sample_pacer.sv
`timescale 1ns/1ps
// Paces buffered 64-bit stereo words out at exactly one per MCLK/fs period (prefill, underrun zero-fill, mute).
// Latency: out_data/out_start register one cycle after the period tick. No input backpressure; a write to a full FIFO is dropped.
// Optional PACER_STATS_EN adds saturating underrun_cnt/overrun_cnt event counters.
module nos_sample_pacer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [63:0]             in_data,
  input  logic                    in_valid,
  input  logic [2:0]              ratio,
  input  logic                    mute,
  input  logic                    clr_flags,
  output logic [63:0]             out_data,
  output logic                    out_start,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    locked,
  output logic                    underrun,
`ifdef PACER_STATS_EN
  output logic [15:0]             underrun_cnt,
  output logic [15:0]             overrun_cnt,
`endif
  output logic                    overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, last;
  logic [2:0]       ratio_q;
  logic [63:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             ratio_chg, tick, full, push, pop, rel_go, unf_set, ovf_set;

  always_comb begin
    case (ratio_q)
      3'd0:    last = CNT_W'(255);
      3'd1:    last = CNT_W'(383);
      3'd2:    last = CNT_W'(511);
      3'd3:    last = CNT_W'(767);
      default: last = CNT_W'(1023);
    endcase
  end

  assign ratio_chg = (ratio != ratio_q);
  assign tick      = (cnt_q == last);
  assign full      = (level == LW'(DEPTH));
  assign locked    = (state_q == RUN);

  // A ratio change overrides everything: no release, no write, FIFO flushed.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rel_go  = 1'b0;
    unf_set = 1'b0;
    if (ratio_chg) begin
      state_d = IDLE;
    end else if (tick) begin
      if (state_q == IDLE) begin
        if (level >= LW'(DEPTH / 2)) state_d = RUN;
      end else begin
        rel_go = 1'b1;
        if (level != '0) begin
          pop = 1'b1;
        end else begin
          unf_set = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign push    = in_valid && !ratio_chg && (!full || pop);
  assign ovf_set = in_valid && !ratio_chg && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ratio_q   <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_start <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio;
      out_start <= rel_go;
      if (rel_go) out_data <= (pop && !mute) ? mem[rd_ptr] : '0;
      if (ratio_chg) begin
        cnt_q  <= '0;
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        level <= level + LW'(push) - LW'(pop);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      underrun <= unf_set | (underrun & ~clr_flags);
      overrun  <= ovf_set | (overrun & ~clr_flags);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef PACER_STATS_EN
  // Event beats clear: a coinciding clear restarts the count at 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (unf_set)
        underrun_cnt <= clr_flags ? 16'd1 :
                        (underrun_cnt == 16'hFFFF) ? underrun_cnt : underrun_cnt + 16'd1;
      else if (clr_flags)
        underrun_cnt <= '0;
      if (ovf_set)
        overrun_cnt <= clr_flags ? 16'd1 :
                       (overrun_cnt == 16'hFFFF) ? overrun_cnt : overrun_cnt + 16'd1;
      else if (clr_flags)
        overrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_nos_sample_pacer.sv
`timescale 1ns/1ps
// Bench for nos_sample_pacer: period table, corner sequences and a randomised run against a queue-based model.
module tb_nos_sample_pacer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] in_data;
  logic        in_valid;
  logic [2:0]  ratio;
  logic        mute;
  logic        clr_flags;
  logic [63:0] out_data;
  logic        out_start;
  logic [2:0]  level;
  logic        locked;
  logic        underrun;
  logic        overrun;
`ifdef PACER_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] overrun_cnt;
`endif

  always #5 clk = ~clk;

  nos_sample_pacer #(.DEPTH(DEPTH), .CNT_W(10)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .ratio        (ratio),
    .mute         (mute),
    .clr_flags    (clr_flags),
    .out_data     (out_data),
    .out_start    (out_start),
    .level        (level),
    .locked       (locked),
    .underrun     (underrun),
`ifdef PACER_STATS_EN
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt),
`endif
    .overrun      (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of words plus the sample-period phase.
  logic [63:0] mq[$];
  int          m_ph, m_rq, m_ucnt, m_ocnt;
  bit          m_run, m_start, m_unf, m_ovf;
  logic [63:0] m_data;

  function automatic int period(int r);
    case (r)
      0:       return 256;
      1:       return 384;
      2:       return 512;
      3:       return 768;
      default: return 1024;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_rq = 0; m_run = 0; m_start = 0;
    m_unf = 0; m_ovf = 0; m_data = '0; m_ucnt = 0; m_ocnt = 0;
  endtask

  task automatic model_step();
    bit          tk, uset, oset;
    logic [63:0] w;
    tk = (m_ph == period(m_rq) - 1);
    uset = 0; oset = 0;
    m_start = 0;
    if (int'(ratio) != m_rq) begin
      mq.delete();
      m_ph  = 0;
      m_run = 0;
    end else begin
      if (tk) begin
        if (!m_run) begin
          if (mq.size() >= DEPTH / 2) m_run = 1;
        end else if (mq.size() > 0) begin
          w = mq.pop_front();
          m_data  = mute ? 64'd0 : w;
          m_start = 1;
        end else begin
          m_data  = 64'd0;
          m_start = 1;
          uset    = 1;
          m_run   = 0;
        end
      end
      if (in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(in_data);
        else oset = 1;
      end
      m_ph = tk ? 0 : m_ph + 1;
    end
    m_rq = int'(ratio);
    if (uset) m_unf = 1; else if (clr_flags) m_unf = 0;
    if (oset) m_ovf = 1; else if (clr_flags) m_ovf = 0;
    if (uset) m_ucnt = clr_flags ? 1 : (m_ucnt < 65535 ? m_ucnt + 1 : m_ucnt);
    else if (clr_flags) m_ucnt = 0;
    if (oset) m_ocnt = clr_flags ? 1 : (m_ocnt < 65535 ? m_ocnt + 1 : m_ocnt);
    else if (clr_flags) m_ocnt = 0;
  endtask

  task automatic check_all();
    chk("out_start", out_start, m_start);
    chk("out_data", out_data, m_data);
    chk("level", level, mq.size());
    chk("locked", locked, m_run);
    chk("underrun", underrun, m_unf);
    chk("overrun", overrun, m_ovf);
`ifdef PACER_STATS_EN
    chk("underrun_cnt", underrun_cnt, m_ucnt);
    chk("overrun_cnt", overrun_cnt, m_ocnt);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    in_valid  = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic push(logic [63:0] w);
    in_data  = w;
    in_valid = 1'b1;
    cycle();
  endtask

  task automatic wait_start(int bound, output int gap);
    gap = 0;
    do begin
      cycle();
      gap++;
    end while (!out_start && gap < bound);
    chk("start_seen", out_start, 1);
  endtask

  // Reset is asserted between edges so its effect is checked asynchronously.
  task automatic do_reset();
    in_valid = 1'b0; clr_flags = 1'b0; mute = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_start", out_start, 0);
    chk("rst_level", level, 0);
    chk("rst_locked", locked, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct {
    logic [2:0] ratio;
    int         period;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int g;
    logic [63:0] wa, wb, wm;
    tbl[0] = '{3'd0, 256};  tbl[1] = '{3'd1, 384};
    tbl[2] = '{3'd2, 512};  tbl[3] = '{3'd3, 768};
    tbl[4] = '{3'd4, 1024}; tbl[5] = '{3'd5, 1024};
    tbl[6] = '{3'd6, 1024}; tbl[7] = '{3'd7, 1024};
    wa = 64'hAAAA_0001_5555_0001;
    wb = 64'hBBBB_0002_6666_0002;
    wm = 64'h1234_5678_9ABC_DEF0;

    resetn = 1'b1; ratio = 3'd0; in_data = '0; in_valid = 1'b0;
    mute = 1'b0; clr_flags = 1'b0;
    #3;
    do_reset();

    // Period per ratio: two prefilled words give two starts exactly one period apart, then a zero word.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ratio = tbl[i].ratio;
      cycle();
      push(wa);
      push(wb);
      wait_start(2 * tbl[i].period + 10, g);
      chk("tbl_first_data", out_data, wa);
      wait_start(tbl[i].period + 10, g);
      chk("tbl_period", g, tbl[i].period);
      chk("tbl_second_data", out_data, wb);
      wait_start(tbl[i].period + 10, g);
      chk("tbl_underrun_gap", g, tbl[i].period);
      chk("tbl_underrun_data", out_data, 0);
      chk("tbl_underrun_flag", underrun, 1);
      chk("tbl_unlocked", locked, 0);
    end

    // Full FIFO overrun, then a write coincident with a pop.
    ratio = 3'd0;
    do_reset();
    for (int i = 0; i < 4; i++) push(wm);
    chk("full_level", level, 4);
    push(wa);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overrun, 1);
    clr_flags = 1'b1;
    cycle();
    chk("ovf_cleared", overrun, 0);
    for (int k = 0; k < 700 && !(m_run && m_ph == period(m_rq) - 1); k++) cycle();
    chk("pop_tick_locked", locked, 1);
    push(wm);
    chk("pop_push_start", out_start, 1);
    chk("pop_push_level", level, 4);
    chk("pop_push_no_ovf", overrun, 0);

    // Mute while running: starts continue carrying zero, FIFO still drains.
    mute = 1'b1;
    wait_start(300, g);
    chk("mute_gap", g, 256);
    chk("mute_data", out_data, 0);
    chk("mute_level1", level, 3);
    wait_start(300, g);
    chk("mute_data2", out_data, 0);
    chk("mute_level2", level, 2);
    mute = 1'b0;

    // Ratio change mid-stream flushes and relocks on the new period.
    do_reset();
    ratio = 3'd1;
    cycle();
    push(wa);
    push(wb);
    wait_start(900, g);
    push(wm);
    repeat (7) cycle();
    ratio = 3'd3;
    cycle();
    chk("rchg_level", level, 0);
    chk("rchg_locked", locked, 0);
    repeat (5) cycle();
    push(wa);
    push(wb);
    for (int k = 0; k < 900 && !locked; k++) cycle();
    chk("rchg_relock", locked, 1);
    wait_start(900, g);
    chk("rchg_first_gap", g, 768);
    chk("rchg_first_data", out_data, wa);

    // Reset during RUN clears outputs immediately.
    chk("pre_reset_locked", locked, 1);
    ratio = 3'd0;
    do_reset();

    // Three forced underruns, then clear.
    for (int r = 0; r < 3; r++) begin
      push(wa);
      push(wb);
      wait_start(600, g);
      wait_start(300, g);
      wait_start(300, g);
      chk("forced_underrun", underrun, 1);
    end
`ifdef PACER_STATS_EN
    chk("underrun_cnt_3", underrun_cnt, 3);
`endif
    clr_flags = 1'b1;
    cycle();
    chk("underrun_clr", underrun, 0);
`ifdef PACER_STATS_EN
    chk("underrun_cnt_clr", underrun_cnt, 0);
`endif

    // Steady stream at ratio 2: one write per period keeps level at 2, no flags.
    do_reset();
    ratio = 3'd2;
    cycle();
    push(wa);
    push(wb);
    wait_start(1100, g);
    for (int i = 0; i < 30; i++) begin
      push({$urandom, $urandom});
      chk("cont_level", level, 2);
      wait_start(600, g);
      chk("cont_gap", g + 1, 512);
    end
    chk("cont_no_underrun", underrun, 0);
    chk("cont_no_overrun", overrun, 0);

    // Randomised traffic at varying write rates.
    ratio = 3'd0;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int rate;
      rate = $urandom_range(120, 450);
      for (int k = 0; k < 2000; k++) begin
        in_valid  = ($urandom_range(0, rate - 1) == 0);
        in_data   = {$urandom, $urandom};
        if ($urandom_range(0, 499) == 0) mute = ~mute;
        clr_flags = ($urandom_range(0, 699) == 0);
        if ($urandom_range(0, 2999) == 0) ratio = 3'($urandom_range(0, 1));
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
